// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with next-PC selection
// (sequential / jump / jump-register / branch), stall and halt handling,
// a continuous/step run-control FSM and a saturating cycle counter.
module pc_sequencer #(
    parameter int                NB_PC    = 32,
    parameter int                NB_ADDR  = 26,
    parameter int                NB_CNT   = 32,
    parameter logic [NB_PC-1:0]  RESET_PC = '0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_mode,
    input  logic                 i_start,
    input  logic                 i_step,
    input  logic                 i_stall,
    input  logic                 i_jump,
    input  logic [NB_ADDR-1:0]   i_jump_index,
    input  logic                 i_jr,
    input  logic [NB_PC-1:0]     i_jr_addr,
    input  logic                 i_branch,
    input  logic [NB_PC-1:0]     i_branch_base,
    input  logic [NB_PC-1:0]     i_branch_offset,
    input  logic                 i_halt,
    output logic [NB_PC-1:0]     o_pc,
    output logic [NB_PC-1:0]     o_pc_plus1,
    output logic                 o_valid,
    output logic [1:0]           o_state,
    output logic [NB_CNT-1:0]    o_cycle_count
);

    localparam logic [NB_PC-1:0]  PC_ONE  = NB_PC'(1);
    localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [NB_PC-1:0]   pc_q;
    logic [NB_PC-1:0]   pc_d;
    logic [NB_CNT-1:0]  cnt_q;
    logic [NB_CNT-1:0]  cnt_d;
    logic               valid;
    logic               advance;
    logic [NB_PC-1:0]   pc_plus1;
    logic [NB_PC-1:0]   jump_target;
    logic [NB_PC-1:0]   branch_target;

    // Candidate next-PC values; the jump keeps the upper region of PC+1.
    always_comb begin
        pc_plus1      = pc_q + PC_ONE;
        jump_target   = {pc_plus1[NB_PC-1:NB_ADDR], i_jump_index};
        branch_target = i_branch_base + i_branch_offset;
    end

    // Run control, fetch gating and next-PC priority selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        valid   = (state_q == ST_RUN) || ((state_q == ST_STEP) && i_step);
        advance = valid && !i_stall;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (advance && i_halt) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (advance && !i_halt) begin
            if (i_jr) begin
                pc_d = i_jr_addr;
            end else if (i_jump) begin
                pc_d = jump_target;
            end else if (i_branch) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus1;
            end
        end

        if (valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State, PC and counter registers; reset wins over everything.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_pc_plus1    = pc_plus1;
    assign o_valid       = valid;
    assign o_state       = state_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives pc_sequencer with directed and random traffic and
// compares every cycle's outputs against a behavioural model.
module tb_pc_sequencer;

    localparam int          NB_PC    = 32;
    localparam int          NB_ADDR  = 26;
    localparam int          NB_CNT   = 6;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam int          CNT_MAX  = 63;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc1;
        logic        valid;
        logic [1:0]  state;
        logic [5:0]  cnt;
    } exp_t;

    logic        clock;
    logic        i_reset, i_mode, i_start, i_step, i_stall;
    logic        i_jump, i_jr, i_branch, i_halt;
    logic [25:0] i_jump_index;
    logic [31:0] i_jr_addr, i_branch_base, i_branch_offset;
    logic [31:0] o_pc, o_pc_plus1;
    logic        o_valid;
    logic [1:0]  o_state;
    logic [5:0]  o_cycle_count;

    logic        s_reset, s_mode, s_start, s_step, s_stall;
    logic        s_jump, s_jr, s_branch, s_halt;
    logic [25:0] s_jump_index;
    logic [31:0] s_jr_addr, s_branch_base, s_branch_offset;

    bit          m_known;
    logic [31:0] m_pc;
    int          m_state;
    int          m_cnt;
    int          halted_cycles;

    exp_t        exp_q[$];
    int          n_compared;
    int          n_mismatched;

    pc_sequencer #(
        .NB_PC(NB_PC), .NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT), .RESET_PC(RESET_PC)
    ) dut (
        .i_clock(clock), .i_reset(i_reset), .i_mode(i_mode), .i_start(i_start),
        .i_step(i_step), .i_stall(i_stall), .i_jump(i_jump),
        .i_jump_index(i_jump_index), .i_jr(i_jr), .i_jr_addr(i_jr_addr),
        .i_branch(i_branch), .i_branch_base(i_branch_base),
        .i_branch_offset(i_branch_offset), .i_halt(i_halt),
        .o_pc(o_pc), .o_pc_plus1(o_pc_plus1), .o_valid(o_valid),
        .o_state(o_state), .o_cycle_count(o_cycle_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endfunction

    task automatic clearStim();
        s_reset = 0; s_mode = 0; s_start = 0; s_step = 0; s_stall = 0;
        s_jump = 0; s_jr = 0; s_branch = 0; s_halt = 0;
        s_jump_index = '0; s_jr_addr = '0; s_branch_base = '0; s_branch_offset = '0;
    endtask

    // One cycle: drive the staged inputs, record what the outputs must be
    // during this cycle, then move the model across the coming edge.
    task automatic applyStimulus();
        exp_t        e;
        bit          v;
        logic [31:0] nxt;
        @(posedge clock);
        #2;
        i_reset = s_reset; i_mode = s_mode; i_start = s_start; i_step = s_step;
        i_stall = s_stall; i_jump = s_jump; i_jr = s_jr; i_branch = s_branch;
        i_halt = s_halt; i_jump_index = s_jump_index; i_jr_addr = s_jr_addr;
        i_branch_base = s_branch_base; i_branch_offset = s_branch_offset;

        v = (m_state == 1) || (m_state == 2 && s_step);
        if (m_known) begin
            e.pc    = m_pc;
            e.pc1   = m_pc + 32'd1;
            e.valid = v;
            e.state = m_state[1:0];
            e.cnt   = m_cnt[5:0];
            exp_q.push_back(e);
        end

        if (s_reset) begin
            m_known = 1;
            m_pc    = RESET_PC;
            m_state = 0;
            m_cnt   = 0;
        end else if (m_known) begin
            if (m_state == 0 && s_start) m_state = s_mode ? 2 : 1;
            if (v && m_cnt < CNT_MAX) m_cnt++;
            if (v && !s_stall) begin
                if (s_halt) begin
                    m_state = 3;
                end else if (s_jr) begin
                    m_pc = s_jr_addr;
                end else if (s_jump) begin
                    nxt  = m_pc + 32'd1;
                    m_pc = ((nxt >> NB_ADDR) << NB_ADDR) | {6'b0, s_jump_index};
                end else if (s_branch) begin
                    m_pc = s_branch_base + s_branch_offset;
                end else begin
                    m_pc = m_pc + 32'd1;
                end
            end
        end
    endtask

    task automatic idleCycles(int n);
        clearStim();
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    // Compare each cycle's outputs with the oldest recorded expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc",        o_pc,          e.pc);
                checkOutput("pc_plus1",  o_pc_plus1,    e.pc1);
                checkOutput("valid",     {31'b0, o_valid},       {31'b0, e.valid});
                checkOutput("state",     {30'b0, o_state},       {30'b0, e.state});
                checkOutput("cycle_cnt", {26'b0, o_cycle_count}, {26'b0, e.cnt});
            end
        end
    end

    // Directed scenarios followed by random traffic.
    initial begin
        n_compared = 0; n_mismatched = 0;
        m_known = 0; m_pc = '0; m_state = 0; m_cnt = 0;
        i_reset = 1; i_mode = 0; i_start = 0; i_step = 0; i_stall = 0;
        i_jump = 0; i_jr = 0; i_branch = 0; i_halt = 0;
        i_jump_index = '0; i_jr_addr = '0; i_branch_base = '0; i_branch_offset = '0;

        clearStim(); s_reset = 1;
        applyStimulus(); applyStimulus();
        #1;
        checkOutput("reset_pc", o_pc, RESET_PC);
        checkOutput("reset_pc_plus1", o_pc_plus1, RESET_PC + 32'd1);

        clearStim(); s_start = 1; applyStimulus();
        idleCycles(6);
        #1;
        checkOutput("run5_pc", o_pc, 32'd5);
        checkOutput("run5_cnt", {26'b0, o_cycle_count}, 32'd5);
        checkOutput("run5_state", {30'b0, o_state}, 32'd1);

        clearStim(); s_jr = 1; s_jr_addr = 32'h1000_0004; applyStimulus();
        clearStim(); s_jump = 1; s_jump_index = 26'h0000123; applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("jump_pc", o_pc, 32'h1000_0123);
        clearStim(); s_jump = 1; s_jump_index = 26'h0000123; s_jr = 1; s_jr_addr = 32'h40;
        applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("jr_over_jump", o_pc, 32'h40);

        clearStim(); s_branch = 1; s_branch_base = 32'h10; s_branch_offset = 32'hFFFF_FFFC;
        applyStimulus();
        clearStim(); s_branch = 1; s_branch_base = 32'hFFFF_FFFF; s_branch_offset = 32'd2;
        applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("branch_wrap", o_pc, 32'h1);

        clearStim(); s_stall = 1; s_jump = 1; s_jump_index = 26'h3FF_FFFF;
        for (int k = 0; k < 3; k++) applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("stall_hold", o_pc, 32'h2);

        clearStim(); s_jr = 1; s_jr_addr = 32'd7; applyStimulus();
        clearStim(); s_halt = 1; s_jump = 1; applyStimulus();
        clearStim(); s_start = 1;
        for (int k = 0; k < 3; k++) applyStimulus();
        #1;
        checkOutput("halt_state", {30'b0, o_state}, 32'd3);
        checkOutput("halt_pc", o_pc, 32'd7);
        clearStim(); s_reset = 1; applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("post_halt_reset_pc", o_pc, RESET_PC);
        checkOutput("post_halt_reset_cnt", {26'b0, o_cycle_count}, 32'd0);

        clearStim(); s_start = 1; s_mode = 1; applyStimulus();
        for (int k = 0; k < 3; k++) begin
            clearStim(); s_step = 1; applyStimulus();
            idleCycles(2);
        end
        clearStim(); s_step = 1; s_stall = 1; applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("step3_pc", o_pc, 32'd3);
        clearStim(); s_step = 1;
        for (int k = 0; k < 3; k++) applyStimulus();
        idleCycles(1);
        #1;
        checkOutput("step_held_pc", o_pc, 32'd6);

        clearStim(); s_reset = 1; applyStimulus();
        clearStim(); s_start = 1; applyStimulus();
        idleCycles(70);
        #1;
        checkOutput("cnt_saturated", {26'b0, o_cycle_count}, 32'd63);

        halted_cycles = 0;
        for (int k = 0; k < 3000; k++) begin
            clearStim();
            halted_cycles = (m_state == 3) ? halted_cycles + 1 : 0;
            s_reset         = ($urandom_range(0, 149) == 0) || (halted_cycles > 8);
            s_start         = ($urandom_range(0, 7) == 0);
            s_mode          = 1'($urandom_range(0, 1));
            s_step          = ($urandom_range(0, 2) == 0);
            s_stall         = ($urandom_range(0, 4) == 0);
            s_jump          = ($urandom_range(0, 5) == 0);
            s_jr            = ($urandom_range(0, 7) == 0);
            s_branch        = ($urandom_range(0, 4) == 0);
            s_halt          = ($urandom_range(0, 59) == 0);
            s_jump_index    = 26'($urandom);
            s_jr_addr       = $urandom;
            s_branch_base   = $urandom;
            s_branch_offset = $urandom;
            applyStimulus();
        end

        idleCycles(2);
        @(negedge clock);
        @(negedge clock);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
